// File: rtl/ts_pkg.sv
// Shared constants and types for the MPEG-2 TS channel monitor: sync/null
// markers, header byte offsets and the alignment FSM encoding.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

  // Byte offsets inside the 4-byte TS header
  localparam int TS_HDR_SYNC_OFS   = 0;
  localparam int TS_HDR_PID_HI_OFS = 1;
  localparam int TS_HDR_PID_LO_OFS = 2;
  localparam int TS_HDR_CC_OFS     = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ts_state_e;

  // Continuity counter only advances when the packet carries payload (AFC bit 0).
  function automatic logic [3:0] next_cc(input logic [3:0] last_cc, input logic [1:0] afc);
    return afc[0] ? last_cc + 4'd1 : last_cc;
  endfunction

endpackage

// File: rtl/ts_activity_timer.sv
// Byte-activity watchdog: valid stays high while strobes keep arriving within
// TIMEOUT_CYC cycles; expire pulses on the cycle whose edge drops valid.
module ts_activity_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic byte_strobe,
  output logic valid,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          seen;
  logic          valid_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    timer_nxt = timer;
    if (byte_strobe) begin
      timer_nxt = '0;
    end else if (timer != TIMEOUT_VAL) begin
      timer_nxt = timer + TW'(1);
    end
    valid_nxt = (seen || byte_strobe) && (timer_nxt < TIMEOUT_VAL);
    expire    = valid && !valid_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer <= '0;
      seen  <= 1'b0;
      valid <= 1'b0;
    end else begin
      timer <= timer_nxt;
      seen  <= seen || byte_strobe;
      valid <= valid_nxt;
    end
  end

endmodule

// File: rtl/ts_channel_monitor.sv
// Per-channel TS front-end: acquires and tracks 188-byte packet alignment,
// checks TEI and the continuity counter of one PID, and counts errors.
module ts_channel_monitor
  import ts_pkg::*;
#(
  parameter int          PKT_LEN     = 188,
  parameter int          LOCK_CNT    = 3,
  parameter int          UNLOCK_CNT  = 3,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [12:0] MON_PID     = 13'h100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] ts_data,
  input  logic       ts_byte_valid,
  input  logic       en_reset_counter,
  output logic       sync,
  output logic       valid,
  output logic [7:0] err_count
);

  localparam int PW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(PKT_LEN - 1);
  localparam logic [PW-1:0] POS_PID_HI = PW'(TS_HDR_PID_HI_OFS);
  localparam logic [PW-1:0] POS_PID_LO = PW'(TS_HDR_PID_LO_OFS);
  localparam logic [PW-1:0] POS_CC     = PW'(TS_HDR_CC_OFS);
  localparam logic [PW-1:0] POS_SYNC   = PW'(TS_HDR_SYNC_OFS);

  ts_state_e     state;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_inc;
  logic [GW-1:0] good;
  logic [MW-1:0] miss;
  logic          tei;
  logic [12:0]   pid;
  logic [3:0]    last_cc;
  logic          cc_valid;
  logic          expire;

  logic is_sync_byte;
  logic cc_monitored;
  logic cc_mismatch;
  logic sync_miss;
  logic hdr_err;
  logic err_event;

  ts_activity_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .byte_strobe(ts_byte_valid),
    .valid      (valid),
    .expire     (expire)
  );

  // Header checks use the PID/TEI captured from bytes 1-2 and the live byte 3.
  always_comb begin
    is_sync_byte = (ts_data == TS_SYNC_BYTE);
    pos_inc      = (pos == POS_LAST) ? '0 : pos + PW'(1);
    cc_monitored = (pid == MON_PID) && (pid != TS_NULL_PID);
    cc_mismatch  = cc_valid && (ts_data[3:0] != next_cc(last_cc, ts_data[5:4]));
    sync_miss    = ts_byte_valid && (state == ST_LOCKED) && (pos == POS_SYNC) && !is_sync_byte;
    hdr_err      = ts_byte_valid && (state == ST_LOCKED) && (pos == POS_CC) &&
                   (tei || (cc_monitored && cc_mismatch));
    err_event    = sync_miss || hdr_err;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_HUNT;
      sync     <= 1'b0;
      pos      <= '0;
      good     <= '0;
      miss     <= '0;
      tei      <= 1'b0;
      pid      <= '0;
      last_cc  <= '0;
      cc_valid <= 1'b0;
    end else if (expire) begin
      // Loss of byte activity invalidates alignment and CC history.
      state    <= ST_HUNT;
      sync     <= 1'b0;
      pos      <= '0;
      good     <= '0;
      miss     <= '0;
      cc_valid <= 1'b0;
    end else if (ts_byte_valid) begin
      pos <= pos_inc;
      case (state)
        ST_HUNT: begin
          if (is_sync_byte) begin
            state <= ST_VERIFY;
            good  <= GW'(1);
            pos   <= PW'(1);
          end else begin
            pos <= '0;
          end
        end

        ST_VERIFY: begin
          if (pos == POS_SYNC) begin
            if (!is_sync_byte) begin
              state <= ST_HUNT;
              good  <= '0;
              pos   <= '0;
            end else begin
              good <= good + GW'(1);
              if (good == GW'(LOCK_CNT - 1)) begin
                state <= ST_LOCKED;
                sync  <= 1'b1;
                miss  <= '0;
              end
            end
          end
        end

        ST_LOCKED: begin
          if (pos == POS_SYNC) begin
            if (is_sync_byte) begin
              miss <= '0;
            end else if (miss == MW'(UNLOCK_CNT - 1)) begin
              state    <= ST_HUNT;
              sync     <= 1'b0;
              pos      <= '0;
              miss     <= '0;
              cc_valid <= 1'b0;
            end else begin
              miss <= miss + MW'(1);
            end
          end else if (pos == POS_PID_HI) begin
            tei        <= ts_data[7];
            pid[12:8]  <= ts_data[4:0];
          end else if (pos == POS_PID_LO) begin
            pid[7:0] <= ts_data;
          end else if (pos == POS_CC && cc_monitored) begin
            last_cc  <= ts_data[3:0];
            cc_valid <= 1'b1;
          end
        end

        default: begin
          state <= ST_HUNT;
          sync  <= 1'b0;
          pos   <= '0;
        end
      endcase
    end
  end

  // A clear from main_control takes priority over a same-cycle error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (en_reset_counter) begin
      err_count <= '0;
    end else if (err_event && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ts_channel_monitor.sv
// Self-checking bench for ts_channel_monitor: directed scenarios plus randomized
// packets, every cycle compared against a byte-level behavioural model.
module tb_ts_channel_monitor;

  localparam int PKT_LEN     = 188;
  localparam int LOCK_CNT    = 3;
  localparam int UNLOCK_CNT  = 3;
  localparam int TIMEOUT_CYC = 1024;
  localparam int MON_PID     = 'h100;
  localparam int OTHER_PID   = 'h200;
  localparam int NULL_PID    = 'h1FFF;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] ts_data = 8'h00;
  logic       ts_byte_valid = 1'b0;
  logic       en_reset_counter = 1'b0;
  logic       sync;
  logic       valid;
  logic [7:0] err_count;

  ts_channel_monitor dut (
    .clk             (clk),
    .rstn            (rstn),
    .ts_data         (ts_data),
    .ts_byte_valid   (ts_byte_valid),
    .en_reset_counter(en_reset_counter),
    .sync            (sync),
    .valid           (valid),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: alignment tracked as a mode (searching / confirming / aligned)
  // with a byte index, header bytes kept and evaluated arithmetically.
  int m_mode, m_good, m_miss, m_idx, m_hdr1, m_hdr2, m_last_cc, m_idle, m_err;
  bit m_have_cc, m_seen, m_valid, m_evt;

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_miss = 0; m_idx = 0; m_hdr1 = 0; m_hdr2 = 0;
    m_last_cc = 0; m_idle = 0; m_err = 0; m_have_cc = 0; m_seen = 0; m_valid = 0;
  endtask

  task automatic model_header(input int d);
    int pid, exp_cc;
    pid = (m_hdr1 % 32) * 256 + m_hdr2;
    if (m_hdr1 >= 128) m_evt = 1;
    if (pid == MON_PID && pid != NULL_PID) begin
      if (m_have_cc) begin
        exp_cc = (((d / 16) % 2) == 1) ? (m_last_cc + 1) % 16 : m_last_cc;
        if ((d % 16) != exp_cc) m_evt = 1;
      end
      m_last_cc = d % 16;
      m_have_cc = 1;
    end
  endtask

  task automatic model_byte(input int d);
    if (m_mode == 0) begin
      if (d == 'h47) begin m_mode = 1; m_good = 1; m_idx = 1; end
      else m_idx = 0;
      return;
    end
    if (m_idx == 0) begin
      if (m_mode == 1) begin
        if (d != 'h47) begin m_mode = 0; m_good = 0; m_idx = 0; return; end
        m_good++;
        if (m_good == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
      end else if (d == 'h47) begin
        m_miss = 0;
      end else begin
        m_evt = 1;
        m_miss++;
        if (m_miss == UNLOCK_CNT) begin
          m_mode = 0; m_miss = 0; m_have_cc = 0; m_idx = 0;
          return;
        end
      end
    end else if (m_mode == 2) begin
      if (m_idx == 1) m_hdr1 = d;
      if (m_idx == 2) m_hdr2 = d;
      if (m_idx == 3) model_header(d);
    end
    m_idx = (m_idx + 1) % PKT_LEN;
  endtask

  task automatic model_step(input bit stb, input int d, input bit clr);
    bit nv;
    m_evt = 0;
    if (stb) begin m_seen = 1; m_idle = 0; end
    else if (m_idle < TIMEOUT_CYC) m_idle++;
    nv = m_seen && (m_idle < TIMEOUT_CYC);
    if (m_valid && !nv) begin
      m_mode = 0; m_idx = 0; m_good = 0; m_miss = 0; m_have_cc = 0;
    end else if (stb) begin
      model_byte(d);
    end
    m_valid = nv;
    if (clr) m_err = 0;
    else if (m_evt && m_err < 255) m_err++;
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic cycle(input bit stb, input logic [7:0] d, input bit clr);
    ts_byte_valid    = stb;
    ts_data          = d;
    en_reset_counter = clr;
    model_step(stb, int'(d), clr);
    @(negedge clk);
    check("sync", int'(sync), int'(m_mode == 2));
    check("valid", int'(valid), int'(m_valid));
    check("err_count", int'(err_count), m_err);
  endtask

  logic [7:0] pkt [PKT_LEN];
  int max_gap = 1;

  task automatic build_pkt(input int pid, input bit tei, input int afc, input int cc,
                           input logic [7:0] sb, input bit rnd_hdr);
    logic [12:0] p;
    logic [7:0]  b;
    logic [1:0]  r;
    p = 13'(pid);
    r = rnd_hdr ? 2'($urandom) : 2'b00;
    pkt[0] = sb;
    pkt[1] = {tei, r, p[12:8]};
    pkt[2] = p[7:0];
    pkt[3] = {(rnd_hdr ? 2'($urandom) : 2'b00), 2'(afc), 4'(cc)};
    for (int i = 4; i < PKT_LEN; i++) begin
      b = 8'($urandom);
      pkt[i] = (b == 8'h47) ? 8'h46 : b;
    end
  endtask

  task automatic send_bytes(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 8'($urandom), 1'b0);
      cycle(1'b1, pkt[i], 1'b0);
    end
  endtask

  task automatic send_pkt(input int pid, input bit tei, input int afc, input int cc,
                          input logic [7:0] sb);
    build_pkt(pid, tei, afc, cc, sb, 1'b0);
    send_bytes(0, PKT_LEN - 1);
  endtask

  int cc;
  int rcc;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sync", int'(sync), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_err", int'(err_count), 0);
    rstn = 1'b1;

    // 1: clean stream locks on the third sync byte
    for (int i = 0; i < 10; i++) send_pkt(MON_PID, 1'b0, 1, i, 8'h47);
    check("t1_sync", int'(sync), 1);
    check("t1_err", int'(err_count), 0);
    check("t1_valid", int'(valid), 1);

    // 2: three corrupted sync bytes drop lock, three clean packets relock
    cc = 10;
    for (int i = 0; i < 3; i++) begin send_pkt(MON_PID, 1'b0, 1, cc, 8'h00); cc++; end
    check("t2_err", int'(err_count), 3);
    check("t2_unlock", int'(sync), 0);
    for (int i = 0; i < 3; i++) begin send_pkt(MON_PID, 1'b0, 1, cc, 8'h47); cc++; end
    check("t2_relock", int'(sync), 1);

    // 3: TEI packet, CC jump 4->6, then a repeated CC without payload
    send_pkt(OTHER_PID, 1'b1, 1, 0, 8'h47);
    for (int i = 0; i <= 4; i++) send_pkt(MON_PID, 1'b0, 1, i, 8'h47);
    send_pkt(MON_PID, 1'b0, 1, 6, 8'h47);
    send_pkt(MON_PID, 1'b0, 1, 7, 8'h47);
    send_pkt(MON_PID, 1'b0, 2, 7, 8'h47);
    send_pkt(MON_PID, 1'b0, 1, 8, 8'h47);
    check("t3_err", int'(err_count), 5);

    // 4: saturation, then a clear colliding with a TEI commit
    max_gap = 0;
    for (int i = 0; i < 300; i++) send_pkt(OTHER_PID, 1'b1, 1, 0, 8'h47);
    check("t4_sat", int'(err_count), 255);
    build_pkt(OTHER_PID, 1'b1, 1, 0, 8'h47, 1'b0);
    send_bytes(0, 2);
    cycle(1'b1, pkt[3], 1'b1);
    check("t4_clear", int'(err_count), 0);
    send_bytes(4, PKT_LEN - 1);
    send_pkt(MON_PID, 1'b0, 1, 9, 8'h47);
    max_gap = 1;

    // 5: activity timeout, then recovery
    repeat (TIMEOUT_CYC + 2) cycle(1'b0, 8'($urandom), 1'b0);
    check("t5_valid_low", int'(valid), 0);
    check("t5_sync_low", int'(sync), 0);
    build_pkt(MON_PID, 1'b0, 1, 0, 8'h47, 1'b0);
    send_bytes(0, 0);
    check("t5_valid_back", int'(valid), 1);
    send_bytes(1, PKT_LEN - 1);
    send_pkt(MON_PID, 1'b0, 1, 1, 8'h47);
    send_pkt(MON_PID, 1'b0, 1, 2, 8'h47);
    check("t5_relock", int'(sync), 1);

    // Randomized packets: mixed PIDs, TEI, CC slips and sync corruption
    rcc = 2;
    for (int i = 0; i < 20; i++) begin
      int pid, afc, c;
      bit tei;
      logic [7:0] sb;
      case ($urandom_range(0, 3))
        0: pid = NULL_PID;
        1: pid = OTHER_PID;
        default: pid = MON_PID;
      endcase
      afc = $urandom_range(1, 3);
      tei = ($urandom_range(0, 7) == 0);
      c   = (afc % 2 == 1) ? (rcc + 1) % 16 : rcc;
      if ($urandom_range(0, 5) == 0) c = $urandom_range(0, 15);
      if (pid == MON_PID) rcc = c;
      sb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 'h46)) : 8'h47;
      build_pkt(pid, tei, afc, c, sb, 1'b1);
      send_bytes(0, PKT_LEN - 1);
    end

    // 6: asynchronous reset mid-packet while locked
    for (int i = 0; i < 3; i++) send_pkt(MON_PID, 1'b0, 1, i, 8'h47);
    check("t6_pre_sync", int'(sync), 1);
    build_pkt(MON_PID, 1'b0, 1, 3, 8'h47, 1'b0);
    send_bytes(0, 49);
    rstn = 1'b0;
    #1;
    check("t6_rst_sync", int'(sync), 0);
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_err", int'(err_count), 0);
    model_reset();
    ts_byte_valid = 1'b0;
    en_reset_counter = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    send_bytes(50, PKT_LEN - 1);
    for (int i = 0; i < 3; i++) send_pkt(MON_PID, 1'b0, 1, 4 + i, 8'h47);
    check("t6_relock", int'(sync), 1);
    check("t6_err", int'(err_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
